// File: rtl/ej32_pkg.sv
// Shared types for the EJ32 8-bit memory bus arbiter: FSM states and owner codes.
package ej32_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_P0   = 2'b01;
  localparam logic [1:0] OWN_P1   = 2'b10;

  // Owner code presented on the bus for a given arbiter state.
  function automatic logic [1:0] own_of(input state_t s);
    case (s)
      BUSY0:   return OWN_P0;
      BUSY1:   return OWN_P1;
      default: return OWN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ej32_rr2.sv
// Two-way round-robin pick: a lone request wins outright; on a tie the port
// that was not granted last wins. last = 1 means port 1 was granted last.
module ej32_rr2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // One-hot grant; zero when nobody is requesting.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/ej32_mb8_arb.sv
// Burst arbiter for the shared 8-bit memory bus: port 0 (core) and port 1
// (host loader/debug) take turns issuing 1..4 byte bursts, one beat per cycle.
// Bus-side outputs are registered one cycle ahead so m_a can hold its last
// value while idle; read bytes return one cycle after each read beat.
module ej32_mb8_arb
  import ej32_pkg::*;
#(
  parameter int ASZ  = 17,
  parameter int BLEN = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0,
  input  logic           req1,
  input  logic           we0,
  input  logic           we1,
  input  logic [ASZ-1:0] a0,
  input  logic [ASZ-1:0] a1,
  input  logic [1:0]     len0,
  input  logic [1:0]     len1,
  input  logic [7:0]     vi0,
  input  logic [7:0]     vi1,
  output logic           ack0,
  output logic           ack1,
  output logic           vld0,
  output logic           vld1,
  output logic [7:0]     vo,
  output logic [ASZ-1:0] m_a,
  output logic           m_we,
  output logic [7:0]     m_vi,
  input  logic [7:0]     m_vo,
  output logic [1:0]     own
);

  // Beat counter width follows the maximum burst length.
  localparam int CW = $clog2(BLEN);

  state_t         state_reg;
  logic           last_reg;      // 1: port 1 was granted most recently
  logic [CW-1:0]  cnt_reg;
  logic [CW-1:0]  len_reg;
  logic [ASZ-1:0] addr_reg;
  logic           we_reg;
  logic [ASZ-1:0] m_a_reg;
  logic           m_we_reg;
  logic [1:0]     ack_reg;
  logic [1:0]     rd_pend_reg;   // read beat issued last cycle, per port

  logic           busy;
  logic           last_beat;
  logic           arb_en;
  logic [1:0]     gnt;
  logic           win;
  logic [ASZ-1:0] win_a;
  logic           win_we;
  logic [CW-1:0]  win_len;
  logic [CW-1:0]  cnt_inc;
  logic [ASZ-1:0] addr_next;

  assign busy      = (state_reg != IDLE);
  assign last_beat = busy && (cnt_reg == len_reg);
  // Arbitrate while idle and on the final beat, so bursts chain with no gap.
  assign arb_en    = (state_reg == IDLE) || last_beat;

  ej32_rr2 u_rr2 (
    .req  ({req1, req0}),
    .last (last_reg),
    .gnt  (gnt)
  );

  assign win     = gnt[1];
  assign win_a   = win ? a1 : a0;
  assign win_we  = win ? we1 : we0;
  assign win_len = win ? len1 : len0;

  // Address wraps naturally at the top of memory through ASZ-bit addition.
  assign cnt_inc   = cnt_reg + 1'b1;
  assign addr_next = addr_reg + ASZ'(cnt_inc);

  // Arbiter FSM with bus-side outputs registered for the upcoming beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      last_reg    <= 1'b1;
      cnt_reg     <= '0;
      len_reg     <= '0;
      addr_reg    <= '0;
      we_reg      <= 1'b0;
      m_a_reg     <= '0;
      m_we_reg    <= 1'b0;
      ack_reg     <= 2'b00;
      rd_pend_reg <= 2'b00;
    end else begin
      rd_pend_reg <= ack_reg & {2{~m_we_reg}};
      if (arb_en && (gnt != 2'b00)) begin
        state_reg <= win ? BUSY1 : BUSY0;
        last_reg  <= win;
        addr_reg  <= win_a;
        we_reg    <= win_we;
        len_reg   <= win_len;
        cnt_reg   <= '0;
        m_a_reg   <= win_a;
        m_we_reg  <= win_we;
        ack_reg   <= gnt;
      end else if (busy && !last_beat) begin
        cnt_reg  <= cnt_inc;
        m_a_reg  <= addr_next;
        m_we_reg <= we_reg;
      end else begin
        state_reg <= IDLE;
        m_we_reg  <= 1'b0;
        ack_reg   <= 2'b00;
      end
    end
  end

  assign ack0 = ack_reg[0];
  assign ack1 = ack_reg[1];
  assign vld0 = rd_pend_reg[0];
  assign vld1 = rd_pend_reg[1];
  assign m_a  = m_a_reg;
  assign m_we = m_we_reg;
  assign m_vi = ack_reg[1] ? vi1 : (ack_reg[0] ? vi0 : 8'h00);
  // Returned byte is shared; gated so the bus reads zero when nothing is valid.
  assign vo   = (|rd_pend_reg) ? m_vo : 8'h00;
  assign own  = own_of(state_reg);

endmodule

// File: tb/tb_ej32_mb8_arb.sv
// Scoreboard bench for ej32_mb8_arb: directed bursts push expected beats and
// read bytes into queues; a monitor compares them as the DUT presents them.
module tb_ej32_mb8_arb;

  typedef struct {
    int          p;
    logic [16:0] a;
    logic        w;
    logic [7:0]  d;
  } beat_t;

  typedef struct {
    int         p;
    logic [7:0] d;
  } rd_t;

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic        req0 = 1'b0;
  logic        req1 = 1'b0;
  logic        we0  = 1'b0;
  logic        we1  = 1'b0;
  logic [16:0] a0   = '0;
  logic [16:0] a1   = '0;
  logic [1:0]  len0 = '0;
  logic [1:0]  len1 = '0;
  logic [7:0]  vi0  = '0;
  logic [7:0]  vi1  = '0;
  logic        ack0, ack1, vld0, vld1, m_we;
  logic [7:0]  vo, m_vi, m_vo;
  logic [16:0] m_a;
  logic [1:0]  own;

  logic [7:0]  mem [0:131071];
  logic        pl_en = 1'b0;
  logic [16:0] pl_a  = '0;
  logic [7:0]  pl_d  = '0;

  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int ack1_seen = 0;
  beat_t beat_q[$];
  rd_t   rd_q[$];

  ej32_mb8_arb #(.ASZ(17), .BLEN(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .a0(a0), .a1(a1), .len0(len0), .len1(len1),
    .vi0(vi0), .vi1(vi1),
    .ack0(ack0), .ack1(ack1), .vld0(vld0), .vld1(vld1), .vo(vo),
    .m_a(m_a), .m_we(m_we), .m_vi(m_vi), .m_vo(m_vo), .own(own)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory: backdoor preload, bus writes, read data one cycle after the address.
  always @(posedge clk) begin
    if (pl_en) mem[pl_a] <= pl_d;
    else if (m_we) mem[m_a] <= m_vi;
    m_vo <= mem[m_a];
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end else begin
      $display("[TB] ok %s = %0h", name, act);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [16:0] addr, input logic [7:0] d);
    pl_en = 1'b1; pl_a = addr; pl_d = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic push(input int p, input logic w, input logic [16:0] addr, input logic [1:0] l,
                      input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2, input logic [7:0] d3);
    logic [7:0] d[4];
    beat_t b;
    rd_t r;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    for (int i = 0; i <= int'(l); i++) begin
      b.p = p; b.a = addr + 17'(i); b.w = w; b.d = d[i];
      beat_q.push_back(b);
      if (!w) begin
        r.p = p; r.d = d[i];
        rd_q.push_back(r);
      end
    end
  endtask

  // Requests a burst, drops req once granted, feeds write bytes per beat.
  task automatic issue(input int p, input logic w, input logic [16:0] addr, input logic [1:0] l,
                       input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2, input logic [7:0] d3,
                       output int gcyc);
    logic [7:0] d[4];
    int beat;
    int n;
    logic ak;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    gcyc = -1; beat = 0; n = 0;
    if (p == 0) begin req0 = 1'b1; we0 = w; a0 = addr; len0 = l; vi0 = d0; end
    else        begin req1 = 1'b1; we1 = w; a1 = addr; len1 = l; vi1 = d0; end
    while (beat <= int'(l) && n < 40) begin
      @(posedge clk); #1;
      n++;
      ak = (p == 0) ? ack0 : ack1;
      if (ak) begin
        if (beat == 0) begin
          gcyc = cyc;
          if (p == 0) req0 = 1'b0; else req1 = 1'b0;
        end
        if (p == 0) vi0 = d[beat]; else vi1 = d[beat];
        beat++;
      end else if (beat > 0) begin
        n = 40;
      end
    end
    tests++;
    if (beat <= int'(l)) begin
      fails++;
      $display("FAIL burst_p%0d_%05h: got %0d beats, required %0d consecutive", p, addr, beat, int'(l) + 1);
      if (p == 0) req0 = 1'b0; else req1 = 1'b0;
    end
  endtask

  task automatic check_vld(input int p, input logic v, input logic pr);
    rd_t r;
    if (v || pr) begin
      tests++;
      if (v !== pr) begin
        fails++;
        $display("FAIL vld_timing_p%0d: got vld=%0d, required %0d", p, v, pr);
      end
    end
    if (v) begin
      tests++;
      if (rd_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_vld_p%0d: got vo=%02h, required no read data", p, vo);
      end else begin
        r = rd_q.pop_front();
        if (r.p != p || vo !== r.d) begin
          fails++;
          $display("FAIL rd_data: got p%0d vo=%02h, required p%0d vo=%02h", p, vo, r.p, r.d);
        end else begin
          $display("[TB] read p%0d vo=%02h ok", p, vo);
        end
      end
    end
  endtask

  task automatic monitor();
    beat_t e;
    logic prev0;
    logic prev1;
    logic ok;
    int p;
    prev0 = 1'b0; prev1 = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev0 = 1'b0; prev1 = 1'b0;
      end else begin
        if (ack0 && ack1) begin
          tests++; fails++;
          $display("FAIL ack_overlap: got ack0=1 ack1=1, required at most one");
        end
        if (ack1) ack1_seen++;
        if (ack0 || ack1) begin
          p = ack1 ? 1 : 0;
          tests++;
          if (beat_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_beat: got p%0d a=%05h we=%0d, required none", p, m_a, m_we);
          end else begin
            e = beat_q.pop_front();
            ok = (p == e.p) && (m_a == e.a) && (m_we == e.w) &&
                 (own == ((e.p == 1) ? 2'b10 : 2'b01)) && (!e.w || m_vi == e.d);
            if (ok) begin
              $display("[TB] beat p%0d a=%05h we=%0d vi=%02h own=%0d ok", p, m_a, m_we, m_vi, own);
            end else begin
              fails++;
              $display("FAIL beat: got p%0d a=%05h we=%0d vi=%02h own=%0d, required p%0d a=%05h we=%0d vi=%02h",
                       p, m_a, m_we, m_vi, own, e.p, e.a, e.w, e.d);
            end
          end
        end
        check_vld(0, vld0, prev0);
        check_vld(1, vld1, prev1);
        prev0 = ack0 && !m_we;
        prev1 = ack1 && !m_we;
      end
    end
  endtask

  initial begin
    int g0;
    int g1;
    int base;
    fork
      monitor();
    join_none

    // Reset with memory preload
    idle(2);
    preload(17'h00100, 8'h11); preload(17'h00101, 8'h22);
    preload(17'h00102, 8'h33); preload(17'h00103, 8'h44);
    preload(17'h00200, 8'hA5); preload(17'h00300, 8'h3C);
    preload(17'h00301, 8'h5E); preload(17'h00400, 8'h99);
    preload(17'h00500, 8'hC0); preload(17'h00501, 8'hC1);
    preload(17'h00502, 8'hC2); preload(17'h00503, 8'hC3);
    chk("rst_own", int'(own), 0);
    chk("rst_acks", int'({ack1, ack0}), 0);
    chk("rst_m_we", int'(m_we), 0);
    chk("rst_vlds", int'({vld1, vld0}), 0);
    chk("rst_m_a", int'(m_a), 0);
    chk("rst_vo", int'(vo), 0);
    rst = 1'b0;
    idle(1);

    // Single 4-beat read on port 0
    push(0, 1'b0, 17'h00100, 2'd3, 8'h11, 8'h22, 8'h33, 8'h44);
    issue(0, 1'b0, 17'h00100, 2'd3, 8'h11, 8'h22, 8'h33, 8'h44, g0);
    idle(3);
    chk("single_idle_own", int'(own), 0);

    // Ties right after reset: port 0 first, then port 1 back-to-back
    rst = 1'b1; idle(1); rst = 1'b0; idle(1);
    push(0, 1'b0, 17'h00200, 2'd0, 8'hA5, 8'h00, 8'h00, 8'h00);
    push(1, 1'b0, 17'h00300, 2'd0, 8'h3C, 8'h00, 8'h00, 8'h00);
    fork
      issue(0, 1'b0, 17'h00200, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00, g0);
      issue(1, 1'b0, 17'h00300, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00, g1);
    join
    chk("tie1_p1_after_p0", g1 - g0, 1);
    idle(2);
    push(0, 1'b1, 17'h00201, 2'd0, 8'h77, 8'h00, 8'h00, 8'h00);
    push(1, 1'b0, 17'h00301, 2'd0, 8'h5E, 8'h00, 8'h00, 8'h00);
    fork
      issue(0, 1'b1, 17'h00201, 2'd0, 8'h77, 8'h00, 8'h00, 8'h00, g0);
      issue(1, 1'b0, 17'h00301, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00, g1);
    join
    chk("tie2_p1_after_p0", g1 - g0, 1);
    idle(2);
    chk("tie2_mem_201", int'(mem[17'h00201]), 8'h77);
    // Port 0 served alone, so the following tie belongs to port 1
    push(0, 1'b0, 17'h00200, 2'd0, 8'hA5, 8'h00, 8'h00, 8'h00);
    issue(0, 1'b0, 17'h00200, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00, g0);
    idle(2);
    push(1, 1'b0, 17'h00300, 2'd0, 8'h3C, 8'h00, 8'h00, 8'h00);
    push(0, 1'b0, 17'h00100, 2'd0, 8'h11, 8'h00, 8'h00, 8'h00);
    fork
      issue(0, 1'b0, 17'h00100, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00, g0);
      issue(1, 1'b0, 17'h00300, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00, g1);
    join
    chk("tie3_p0_after_p1", g0 - g1, 1);
    idle(2);

    // Write burst wrapping past the top of memory, then read it back
    push(1, 1'b1, 17'h1FFFE, 2'd3, 8'hA1, 8'hA2, 8'hA3, 8'hA4);
    issue(1, 1'b1, 17'h1FFFE, 2'd3, 8'hA1, 8'hA2, 8'hA3, 8'hA4, g1);
    idle(2);
    push(0, 1'b0, 17'h1FFFE, 2'd3, 8'hA1, 8'hA2, 8'hA3, 8'hA4);
    issue(0, 1'b0, 17'h1FFFE, 2'd3, 8'h00, 8'h00, 8'h00, 8'h00, g0);
    idle(3);
    chk("wrap_mem_1fffe", int'(mem[17'h1FFFE]), 8'hA1);
    chk("wrap_mem_1ffff", int'(mem[17'h1FFFF]), 8'hA2);
    chk("wrap_mem_00000", int'(mem[17'h00000]), 8'hA3);
    chk("wrap_mem_00001", int'(mem[17'h00001]), 8'hA4);

    // Handoff: port 0 requests during a port-1 burst
    push(1, 1'b1, 17'h00400, 2'd3, 8'h01, 8'h02, 8'h03, 8'h04);
    push(0, 1'b0, 17'h00400, 2'd0, 8'h01, 8'h00, 8'h00, 8'h00);
    fork
      issue(1, 1'b1, 17'h00400, 2'd3, 8'h01, 8'h02, 8'h03, 8'h04, g1);
      begin
        idle(2);
        issue(0, 1'b0, 17'h00400, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00, g0);
      end
    join
    chk("handoff_gap", g0 - g1, 4);
    idle(3);

    // Withdrawn request: one-cycle req1 pulse mid-burst of port 0
    base = ack1_seen;
    push(0, 1'b0, 17'h00100, 2'd3, 8'h11, 8'h22, 8'h33, 8'h44);
    fork
      issue(0, 1'b0, 17'h00100, 2'd3, 8'h00, 8'h00, 8'h00, 8'h00, g0);
      begin
        idle(2);
        req1 = 1'b1; we1 = 1'b0; a1 = 17'h00300; len1 = 2'd0;
        idle(1);
        req1 = 1'b0;
      end
    join
    idle(4);
    chk("withdraw_no_ack1", ack1_seen - base, 0);
    chk("withdraw_own", int'(own), 0);

    // Reset during a 4-beat write after its second beat
    push(0, 1'b1, 17'h00500, 2'd1, 8'hD0, 8'hD1, 8'h00, 8'h00);
    req0 = 1'b1; we0 = 1'b1; a0 = 17'h00500; len0 = 2'd3; vi0 = 8'hD0;
    idle(1);
    chk("rstmid_grant", int'(ack0), 1);
    req0 = 1'b0;
    idle(1);
    vi0 = 8'hD1;
    idle(1);
    rst = 1'b1;
    #1;
    chk("rstmid_m_we", int'(m_we), 0);
    chk("rstmid_ack0", int'(ack0), 0);
    idle(1);
    rst = 1'b0; we0 = 1'b0;
    idle(3);
    chk("rstmid_own", int'(own), 0);
    chk("rstmid_mem_500", int'(mem[17'h00500]), 8'hD0);
    chk("rstmid_mem_501", int'(mem[17'h00501]), 8'hD1);
    chk("rstmid_mem_502", int'(mem[17'h00502]), 8'hC2);
    chk("rstmid_mem_503", int'(mem[17'h00503]), 8'hC3);

    idle(3);
    chk("beats_drained", beat_q.size(), 0);
    chk("reads_drained", rd_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
